// File: rtl/sort_pkg.sv
// Shared types for the 3-input compare-exchange sorting network.
`default_nettype none
package sort_pkg;

  typedef logic [31:0] data_t;

  localparam int WINDOW = 3;

  typedef struct packed {
    logic  valid;
    data_t lane0;
    data_t lane1;
    data_t lane2;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/cmp_swap.sv
// Combinational compare-exchange: equal operands keep their order.
`default_nettype none
module cmp_swap #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic keep;

  assign keep = (a <= b);
  assign lo   = keep ? a : b;
  assign hi   = keep ? b : a;

endmodule
`default_nettype wire

// File: rtl/median_stream_3.sv
// Sliding 3-sample window feeding a registered 3-stage sorter with valid/ready flow control.
`default_nettype none
module median_stream_3
  import sort_pkg::*;
#(
  parameter int WIDTH = $bits(data_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_med,
  output logic [WIDTH-1:0] out_max
);

  localparam logic [1:0] FULL = 2'(WINDOW);

  data_t      w0, w1, w2;
  logic       win_valid;
  logic [1:0] fill;
  logic [1:0] fill_base;
  logic [1:0] fill_next;
  logic       en;
  logic       accept;
  logic       launch;
  stage_t     s0, s1, s2;

  data_t lo0, hi0, lo1, hi1, lo2, hi2;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // A flush restarts the count; an accept in the same cycle then counts as the first sample.
  always_comb begin
    fill_base = flush ? 2'd0 : fill;
    fill_next = fill_base;
    if (accept && (fill_base != FULL)) begin
      fill_next = fill_base + 2'd1;
    end
  end

  assign launch = accept && (fill_next == FULL);

  cmp_swap #(.WIDTH($bits(data_t))) u_cmp0 (.a(w0),       .b(w1),       .lo(lo0), .hi(hi0));
  cmp_swap #(.WIDTH($bits(data_t))) u_cmp1 (.a(s0.lane1), .b(s0.lane2), .lo(lo1), .hi(hi1));
  cmp_swap #(.WIDTH($bits(data_t))) u_cmp2 (.a(s1.lane0), .b(s1.lane1), .lo(lo2), .hi(hi2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      win_valid <= 1'b0;
      fill      <= 2'd0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
    end else begin
      if (flush || accept) begin
        fill <= fill_next;
      end
      if (en) begin
        if (accept) begin
          w2 <= w1;
          w1 <= w0;
          w0 <= in_data;
        end
        win_valid <= launch;
        s0        <= '{valid: win_valid, lane0: lo0, lane1: hi0, lane2: w2};
        s1        <= '{valid: s0.valid, lane0: s0.lane0, lane1: lo1, lane2: hi1};
        s2        <= '{valid: s1.valid, lane0: lo2, lane1: hi2, lane2: s1.lane2};
      end
    end
  end

  assign out_valid = s2.valid;
  assign out_min   = s2.lane0;
  assign out_med   = s2.lane1;
  assign out_max   = s2.lane2;

endmodule
`default_nettype wire

// File: tb/tb_median_stream_3.sv
// Randomized and directed bench for median_stream_3 against a window/queue reference model.
`default_nettype none
module tb_median_stream_3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_min, out_med, out_max;

  median_stream_3 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_med(out_med), .out_max(out_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mn;
    logic [31:0] md;
    logic [31:0] mx;
  } res_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference: min and max by scanning, median as what remains of the sum.
  function automatic res_t ref_sort(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    res_t r;
    longint unsigned s;
    s = longint'(a) + longint'(b) + longint'(c);
    r.mn = a; if (b < r.mn) r.mn = b; if (c < r.mn) r.mn = c;
    r.mx = a; if (b > r.mx) r.mx = b; if (c > r.mx) r.mx = c;
    r.md = 32'(s - longint'(r.mn) - longint'(r.mx));
    return r;
  endfunction

  res_t        exp_q[$];
  logic [31:0] hist[3];
  int          mfill = 0;
  bit          rst_pending = 0;
  bit          stall_prev = 0;
  logic [31:0] sv_min, sv_med, sv_max;

  always @(negedge clk) begin
    if (rst_pending) begin
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_min", out_min, 32'd0);
      check_val("rst_out_med", out_med, 32'd0);
      check_val("rst_out_max", out_max, 32'd0);
      rst_pending = 0;
    end
    if (!rst_n) begin
      exp_q.delete();
      mfill       = 0;
      rst_pending = 1;
      stall_prev  = 0;
    end else begin
      check_val("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stall_prev) begin
        check_val("hold_valid", 32'(out_valid), 32'd1);
        check_val("hold_min", out_min, sv_min);
        check_val("hold_med", out_med, sv_med);
        check_val("hold_max", out_max, sv_max);
      end
      if (out_valid && exp_q.size() == 0) begin
        check_val("spurious_out_valid", 32'd1, 32'd0);
      end else if (out_valid && out_ready) begin
        res_t e;
        e = exp_q.pop_front();
        check_val("out_min", out_min, e.mn);
        check_val("out_med", out_med, e.md);
        check_val("out_max", out_max, e.mx);
      end
      stall_prev = out_valid && !out_ready;
      sv_min = out_min; sv_med = out_med; sv_max = out_max;
      if (flush) mfill = 0;
      if (in_valid && in_ready) begin
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = in_data;
        if (mfill < 3) mfill++;
        if (mfill == 3) exp_q.push_back(ref_sort(hist[0], hist[1], hist[2]));
      end
    end
  end

  task automatic send(input logic [31:0] v);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = v;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic expect_window(input string tag, input logic [31:0] mn, input logic [31:0] md,
                               input logic [31:0] mx);
    bit seen;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      check_val({tag, "_min"}, out_min, mn);
      check_val({tag, "_med"}, out_med, md);
      check_val({tag, "_max"}, out_max, mx);
    end
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Warm-up and latency
    send(32'd5); send(32'd1); send(32'd3);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check_val("latency", 32'(lat), 32'd4);
    check_val("warm_min", out_min, 32'd1);
    check_val("warm_med", out_med, 32'd3);
    check_val("warm_max", out_max, 32'd5);

    // Sliding
    send(32'd9); send(32'd0);
    idle(6);

    // Backpressure while samples keep arriving
    fork
      begin
        send(32'd2); send(32'd6); send(32'd1); send(32'd7);
      end
      begin
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(8);

    // Unsigned extremes and equal values
    flush_pulse();
    send(32'hFFFF_FFFF); send(32'd0); send(32'hFFFF_FFFF);
    expect_window("unsigned", 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(4);
    flush_pulse();
    send(32'd7); send(32'd7); send(32'd7);
    expect_window("equal", 32'd7, 32'd7, 32'd7);
    idle(4);

    // Flush restarts window fill
    send(32'd11); send(32'd12); send(32'd13);
    idle(6);
    flush_pulse();
    send(32'd2); send(32'd4);
    idle(6);
    check_val("flush_quiet", 32'(out_valid), 32'd0);
    send(32'd6);
    expect_window("flush", 32'd2, 32'd4, 32'd6);
    idle(4);

    // Reset one cycle after a launching accept
    send(32'd10); send(32'd20); send(32'd30);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    send(32'd5); send(32'd6);
    idle(6);
    check_val("post_rst_quiet", 32'(out_valid), 32'd0);
    send(32'd4);
    expect_window("post_rst", 32'd4, 32'd5, 32'd6);
    idle(4);

    // Randomized traffic with flow control and occasional flush
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = ($urandom % 2 != 0) ? 32'($urandom_range(0, 7)) : $urandom;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(10);
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/median_stream_3.md
# median_stream_3

Streaming front/back end for the 3-input compare-exchange sorting network. Accepts one unsigned sample per handshake, keeps a sliding window of the three most recent samples, sorts the window through a registered 3-stage compare-exchange pipeline, and emits min/median/max per sample with valid/ready backpressure. Sits between a sample source and any consumer that needs a 3-tap median filter, turning a serial stream into parallel sorter words and back.

## Interface

- WIDTH, 32, sample width in bits; unsigned compare throughout
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- flush  input  1  clears the window fill count; pipeline contents still drain
- in_valid  input  1  in_data is presented
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  WIDTH  sample
- out_valid  output  1  out_* hold a sorted window
- out_ready  input  1  consumer accepts out_* this cycle
- out_min  output  WIDTH  smallest of window
- out_med  output  WIDTH  median of window
- out_max  output  WIDTH  largest of window

## Operation

- Window: three WIDTH registers w0 (newest), w1, w2 (oldest) plus 2-bit fill count (0..3, saturating at 3).
- Accept when in_valid && in_ready: w2<=w1, w1<=w0, w0<=in_data; fill increments to max 3.
- A window is launched into the pipeline on an accept only if fill (after increment) is 3; first two samples after reset/flush produce no output.
- Pipeline stages, each registered with its own valid bit:
  - S0: compare-exchange (w0,w1) -> (lo,hi); w2 passes.
  - S1: compare-exchange (S0.hi, w2); S0.lo passes.
  - S2: compare-exchange (S1.lo-lane, S1.mid-lane); S1.max passes. S2 regs drive out_min/out_med/out_max.
- Compare is a <= b keeps order (equal values do not swap).
- Global advance enable en = !out_valid || out_ready. When en low, window, fill and all stage registers hold.
- in_ready = en. Bubbles (invalid stages) are not collapsed during stalls.
- flush: on a cycle with flush high, fill <= 0; an accept in the same cycle still shifts in_data and sets fill to 1. Window data registers are not cleared. Stages already launched drain normally.
- rst_n low at clock edge: fill=0, all stage valids=0, out_valid=0, out_min/out_med/out_max=0, window regs=0. Reset mid-operation discards in-flight results; no partial output appears afterwards.

## Timing

- Latency: sample accepted at edge E0 (completing a full window) -> S0 at E1, S1 at E2, out_valid high after E3 with no stall.
- Throughput: one result per cycle while in_valid high and out_ready high.
- Output hold: while out_valid && !out_ready, out_* and out_valid stable; in_ready low same cycle (combinational from out_ready).
- out_valid deasserts only after a handshake with no new valid in S1 behind it.
- Simultaneous in handshake and out handshake in the same cycle: both complete, pipeline advances.
- No combinational path from in_valid/in_data to any output; in_ready depends only on out_valid and out_ready.

## Structure

- Shared package sort_pkg: data_t (logic [31:0]), WINDOW=3 constant, stage struct {valid, lane0..lane2}.
- One sub-module natural: cmp_swap (combinational WIDTH-bit compare-exchange, outputs lo/hi); instantiate three times, one per stage.
- Window/fill logic and stage registers live in median_stream_3.

## Test plan

- Warm-up: reset, send 5,1,3 back-to-back, out_ready=1 -> no out_valid for first two; after E3 of third accept out_min=1, out_med=3, out_max=5.
- Sliding: continue with 9 then 0 -> windows {1,3,9} med 3 max 9, then {3,9,0} min 0 med 3 max 9, on consecutive cycles.
- Backpressure: hold out_ready=0 for 4 cycles with out_valid high -> out_* stable, in_ready=0, no samples lost; release -> remaining results in order.
- Unsigned/equal: 0xFFFFFFFF, 0, 0xFFFFFFFF -> min 0, med 0xFFFFFFFF, max 0xFFFFFFFF; 7,7,7 -> all 7.
- Flush: after full window, pulse flush with no accept, send 2,4 -> no new output; send 6 -> min 2, med 4, max 6.
- Reset mid-flight: assert rst_n=0 one cycle after a launching accept -> all outputs 0, out_valid stays 0 until three new samples received.
